// File: rtl/ctrl_wb_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_wb_pipe
//   Back-end control pipeline, E through W, for a classic five-stage MIPS-like
//   core. The instruction sitting in D is decoded into a small control record
//   {we, waddr, wdsel, tnew}. That record then moves through STAGES registers.
//   The last register drives register-file write-back. Every stage's record is
//   exported, and a combinational RAW stall request is computed from the
//   in-flight records against the two source registers queried by D.
//
// Parameters
//   STAGES  stages after D (0=E, 1=M, ..., STAGES-1=W), legal range 2..6
//   AW      register address width
//   TW      Tnew/Tuse field width
//
// Ports
//   clk, rst_n                 rising-edge clock, async active-low reset
//   d_valid, d_op, d_func,     instruction currently held in D
//   d_rt, d_rd
//   stall                      bubble into stage 0, later stages advance
//   hold                       freeze every stage (also masks stall)
//   flush                      clear every stage to a bubble (beats hold)
//   q_rs, q_rt                 source registers read by the D instruction
//   q_tuse_rs, q_tuse_rt       cycles until D needs each source
//   st_we/st_waddr/st_wdsel/   packed per-stage records, stage i at slice i
//   st_tnew
//   rf_we/rf_waddr/rf_wdsel    copy of the last stage, for RF write-back
//   stall_req                  RAW hazard request, purely combinational
// ---------------------------------------------------------------------------
module ctrl_wb_pipe #(
  parameter int STAGES = 3,
  parameter int AW     = 5,
  parameter int TW     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   d_valid,
  input  logic [5:0]             d_op,
  input  logic [5:0]             d_func,
  input  logic [AW-1:0]          d_rt,
  input  logic [AW-1:0]          d_rd,
  input  logic                   stall,
  input  logic                   hold,
  input  logic                   flush,
  input  logic [AW-1:0]          q_rs,
  input  logic [AW-1:0]          q_rt,
  input  logic [TW-1:0]          q_tuse_rs,
  input  logic [TW-1:0]          q_tuse_rt,
  output logic [STAGES-1:0]      st_we,
  output logic [STAGES*AW-1:0]   st_waddr,
  output logic [STAGES*2-1:0]    st_wdsel,
  output logic [STAGES*TW-1:0]   st_tnew,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_waddr,
  output logic [1:0]             rf_wdsel,
  output logic                   stall_req
);

  // Opcode / funct values recognised by the decoder.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // Write-data source select.
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [TW-1:0] TNEW_ALU = TW'(1);
  localparam logic [TW-1:0] TNEW_DM  = TW'(2);
  localparam logic [TW-1:0] TNEW_PC4 = TW'(0);
  localparam logic [AW-1:0] RA_ADDR  = AW'(31);

  // -------------------------------------------------------------------------
  // Decode of the D-stage instruction
  // -------------------------------------------------------------------------
  logic          dec_hit;
  logic          dec_we;
  logic [AW-1:0] dec_waddr;
  logic [1:0]    dec_wdsel;
  logic [TW-1:0] dec_tnew;

  always_comb begin
    dec_hit   = 1'b0;
    dec_waddr = '0;
    dec_wdsel = WD_ALU;
    dec_tnew  = '0;
    if (d_valid) begin
      case (d_op)
        OP_RTYPE: begin
          if (d_func == FN_ADDU || d_func == FN_SUBU) begin
            dec_hit   = 1'b1;
            dec_waddr = d_rd;
            dec_wdsel = WD_ALU;
            dec_tnew  = TNEW_ALU;
          end
        end
        OP_ORI, OP_LUI: begin
          dec_hit   = 1'b1;
          dec_waddr = d_rt;
          dec_wdsel = WD_ALU;
          dec_tnew  = TNEW_ALU;
        end
        OP_LW: begin
          dec_hit   = 1'b1;
          dec_waddr = d_rt;
          dec_wdsel = WD_DM;
          dec_tnew  = TNEW_DM;
        end
        OP_JAL: begin
          dec_hit   = 1'b1;
          dec_waddr = RA_ADDR;
          dec_wdsel = WD_PC4;
          dec_tnew  = TNEW_PC4;
        end
        default: begin
          dec_hit = 1'b0;
        end
      endcase
    end
  end

  // Writes to $0 are architecturally discarded, so they never count as
  // producers and never reach the register file.
  assign dec_we = dec_hit && (dec_waddr != '0);

  // Saturating decrement: a result that is already available stays at 0.
  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : (t - TW'(1));
  endfunction

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  logic          we_q    [STAGES];
  logic [AW-1:0] waddr_q [STAGES];
  logic [1:0]    wdsel_q [STAGES];
  logic [TW-1:0] tnew_q  [STAGES];

  logic          we_d    [STAGES];
  logic [AW-1:0] waddr_d [STAGES];
  logic [1:0]    wdsel_d [STAGES];
  logic [TW-1:0] tnew_d  [STAGES];

  logic [STAGES-1:0] hit_rs;
  logic [STAGES-1:0] hit_rt;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      // Stage 0 takes the decoded record, or a bubble while D is stalled.
      always_comb begin
        we_d[gi]    = we_q[gi];
        waddr_d[gi] = waddr_q[gi];
        wdsel_d[gi] = wdsel_q[gi];
        tnew_d[gi]  = tnew_q[gi];
        if (flush || (!hold && stall)) begin
          we_d[gi]    = 1'b0;
          waddr_d[gi] = '0;
          wdsel_d[gi] = WD_ALU;
          tnew_d[gi]  = '0;
        end else if (!hold) begin
          we_d[gi]    = dec_we;
          waddr_d[gi] = dec_waddr;
          wdsel_d[gi] = dec_wdsel;
          tnew_d[gi]  = dec_tnew;
        end
      end
    end else begin : g_rest
      // Later stages shift forward whenever not held. A stall only blocks D,
      // so a record moving one stage on is one cycle closer to its result and
      // its Tnew drops on every advance.
      always_comb begin
        we_d[gi]    = we_q[gi];
        waddr_d[gi] = waddr_q[gi];
        wdsel_d[gi] = wdsel_q[gi];
        tnew_d[gi]  = tnew_q[gi];
        if (flush) begin
          we_d[gi]    = 1'b0;
          waddr_d[gi] = '0;
          wdsel_d[gi] = WD_ALU;
          tnew_d[gi]  = '0;
        end else if (!hold) begin
          we_d[gi]    = we_q[gi-1];
          waddr_d[gi] = waddr_q[gi-1];
          wdsel_d[gi] = wdsel_q[gi-1];
          tnew_d[gi]  = tnew_dec(tnew_q[gi-1]);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        we_q[gi]    <= 1'b0;
        waddr_q[gi] <= '0;
        wdsel_q[gi] <= WD_ALU;
        tnew_q[gi]  <= '0;
      end else begin
        we_q[gi]    <= we_d[gi];
        waddr_q[gi] <= waddr_d[gi];
        wdsel_q[gi] <= wdsel_d[gi];
        tnew_q[gi]  <= tnew_d[gi];
      end
    end

    // Export the packed per-stage view.
    assign st_we[gi]              = we_q[gi];
    assign st_waddr[gi*AW +: AW]  = waddr_q[gi];
    assign st_wdsel[gi*2 +: 2]    = wdsel_q[gi];
    assign st_tnew[gi*TW +: TW]   = tnew_q[gi];

    // RAW hazard: this stage will write a register that D reads before the
    // value can be forwarded (its result arrives later than D needs it).
    assign hit_rs[gi] = we_q[gi] && (waddr_q[gi] == q_rs) && (q_rs != '0)
                        && (tnew_q[gi] > q_tuse_rs);
    assign hit_rt[gi] = we_q[gi] && (waddr_q[gi] == q_rt) && (q_rt != '0)
                        && (tnew_q[gi] > q_tuse_rt);
  end

  assign stall_req = |(hit_rs | hit_rt);

  // -------------------------------------------------------------------------
  // Register-file write-back from the last stage
  // -------------------------------------------------------------------------
  assign rf_we    = we_q[STAGES-1];
  assign rf_waddr = waddr_q[STAGES-1];
  assign rf_wdsel = wdsel_q[STAGES-1];

endmodule

// File: tb/tb_ctrl_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_wb_pipe
//   Directed test of ctrl_wb_pipe. Two instances share one stimulus stream:
//   the default 3-stage pipe and a 5-stage pipe. The stimulus pushes the
//   expected value of a chosen output for a given cycle into a scoreboard. A
//   monitor compares every entry that is due on the falling edge of that
//   cycle.
// ---------------------------------------------------------------------------
module tb_ctrl_wb_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, d_valid, stall, hold, flush;
  logic [5:0]  d_op, d_func;
  logic [4:0]  d_rt, d_rd, q_rs, q_rt;
  logic [1:0]  q_tuse_rs, q_tuse_rt;

  logic [2:0]  st_we;
  logic [14:0] st_waddr;
  logic [5:0]  st_wdsel, st_tnew;
  logic        rf_we, stall_req;
  logic [4:0]  rf_waddr;
  logic [1:0]  rf_wdsel;

  logic [4:0]  st_we5;
  logic [24:0] st_waddr5;
  logic [9:0]  st_wdsel5, st_tnew5;
  logic        rf_we5, stall_req5;
  logic [4:0]  rf_waddr5;
  logic [1:0]  rf_wdsel5;

  ctrl_wb_pipe #(.STAGES(3), .AW(5), .TW(2)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_op(d_op), .d_func(d_func),
    .d_rt(d_rt), .d_rd(d_rd), .stall(stall), .hold(hold), .flush(flush),
    .q_rs(q_rs), .q_rt(q_rt), .q_tuse_rs(q_tuse_rs), .q_tuse_rt(q_tuse_rt),
    .st_we(st_we), .st_waddr(st_waddr), .st_wdsel(st_wdsel), .st_tnew(st_tnew),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdsel(rf_wdsel), .stall_req(stall_req)
  );

  ctrl_wb_pipe #(.STAGES(5), .AW(5), .TW(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_op(d_op), .d_func(d_func),
    .d_rt(d_rt), .d_rd(d_rd), .stall(stall), .hold(hold), .flush(flush),
    .q_rs(q_rs), .q_rt(q_rt), .q_tuse_rs(q_tuse_rs), .q_tuse_rt(q_tuse_rt),
    .st_we(st_we5), .st_waddr(st_waddr5), .st_wdsel(st_wdsel5), .st_tnew(st_tnew5),
    .rf_we(rf_we5), .rf_waddr(rf_waddr5), .rf_wdsel(rf_wdsel5), .stall_req(stall_req5)
  );

  // Output selectors used by scoreboard entries.
  localparam int S_WE = 0, S_WADDR = 1, S_WDSEL = 2, S_TNEW = 3;
  localparam int S_RFWE = 4, S_RFWADDR = 5, S_RFWDSEL = 6, S_STALL = 7;
  localparam int S5_WE = 8, S5_TNEW = 9, S5_RFWE = 10, S5_RFWADDR = 11, S5_RFWDSEL = 12;

  typedef struct {
    int          cyc;
    int          sig;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sig_val(input int sig);
    case (sig)
      S_WE:       return 64'(st_we);
      S_WADDR:    return 64'(st_waddr);
      S_WDSEL:    return 64'(st_wdsel);
      S_TNEW:     return 64'(st_tnew);
      S_RFWE:     return 64'(rf_we);
      S_RFWADDR:  return 64'(rf_waddr);
      S_RFWDSEL:  return 64'(rf_wdsel);
      S_STALL:    return 64'(stall_req);
      S5_WE:      return 64'(st_we5);
      S5_TNEW:    return 64'(st_tnew5);
      S5_RFWE:    return 64'(rf_we5);
      S5_RFWADDR: return 64'(rf_waddr5);
      S5_RFWDSEL: return 64'(rf_wdsel5);
      default:    return 64'hdead_beef;
    endcase
  endfunction

  // Monitor: compare every scoreboard entry that falls due this cycle.
  always @(negedge clk) begin
    logic [63:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = sig_val(sb[i].sig);
        n_checks++;
        if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                   sb[i].name, cyc, act, sb[i].val);
        end else begin
          $display("ok   %s cyc=%0d value=%0h", sb[i].name, cyc, act);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int at, input int sig, input logic [63:0] val,
                           input string name);
    exp_t e;
    e.cyc = at; e.sig = sig; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rt, input logic [4:0] rd);
    d_valid = 1'b1; d_op = op; d_func = fn; d_rt = rt; d_rd = rd;
  endtask

  task automatic bubble();
    d_valid = 1'b0; d_op = 6'h00; d_func = 6'h00; d_rt = 5'd0; d_rd = 5'd0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b0; stall = 1'b0; hold = 1'b0; flush = 1'b0;
    q_rs = 5'd0; q_rt = 5'd0; q_tuse_rs = 2'd0; q_tuse_rt = 2'd0;
    bubble();

    // 1. Reset state, then addu rd=8 through the 3-stage pipe.
    tick();
    n_checks++;
    if (st_we !== 3'b000) begin
      n_fail++;
      $display("FAIL direct_reset_st_we cyc=%0d actual=%0h required=0", cyc, st_we);
    end else begin
      $display("ok   direct_reset_st_we cyc=%0d value=%0h", cyc, st_we);
    end
    n_checks++;
    if (st_waddr !== 15'd0) begin
      n_fail++;
      $display("FAIL direct_reset_st_waddr cyc=%0d actual=%0h required=0", cyc, st_waddr);
    end else begin
      $display("ok   direct_reset_st_waddr cyc=%0d value=%0h", cyc, st_waddr);
    end
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_reset_rf_we cyc=%0d actual=%0h required=0", cyc, rf_we);
    end else begin
      $display("ok   direct_reset_rf_we cyc=%0d value=%0h", cyc, rf_we);
    end
    n_checks++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_reset_stall_req cyc=%0d actual=%0h required=0", cyc, stall_req);
    end else begin
      $display("ok   direct_reset_stall_req cyc=%0d value=%0h", cyc, stall_req);
    end
    n_checks++;
    if (rf_we5 !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_reset_rf_we5 cyc=%0d actual=%0h required=0", cyc, rf_we5);
    end else begin
      $display("ok   direct_reset_rf_we5 cyc=%0d value=%0h", cyc, rf_we5);
    end
    t = cyc;
    expect_at(t, S_WE,    0, "reset_st_we");
    expect_at(t, S_WADDR, 0, "reset_st_waddr");
    expect_at(t, S_RFWE,  0, "reset_rf_we");
    expect_at(t, S_STALL, 0, "reset_stall_req");
    expect_at(t, S5_WE,   0, "reset_st_we5");
    tick();
    rst_n = 1'b1;
    t = cyc;
    drive(6'h00, 6'h21, 5'd3, 5'd8);
    expect_at(t+1, S_WE,      3'b001, "addu_st_we");
    expect_at(t+1, S_WADDR,   15'd8,  "addu_st_waddr");
    expect_at(t+1, S_TNEW,    6'd1,   "addu_st_tnew");
    expect_at(t+1, S_WDSEL,   6'd0,   "addu_st_wdsel");
    expect_at(t+3, S_RFWE,    1,      "addu_rf_we");
    expect_at(t+3, S_RFWADDR, 8,      "addu_rf_waddr");
    expect_at(t+3, S_WE,      3'b100, "addu_st_we_w");
    expect_at(t+4, S_RFWE,    0,      "addu_rf_we_gone");
    tick(); bubble();
    tick(); tick(); tick();

    // 2. lw rt=9 followed by a dependent addu: stall while lw is in E and M.
    t = cyc;
    drive(6'h23, 6'h00, 5'd9, 5'd0);
    tick();
    drive(6'h00, 6'h21, 5'd0, 5'd10);
    q_rs = 5'd9; q_tuse_rs = 2'd0; stall = 1'b1;
    expect_at(t+1, S_STALL, 1,      "lw_e_stall_req");
    expect_at(t+1, S_TNEW,  6'd2,   "lw_e_tnew");
    tick();
    expect_at(t+2, S_STALL, 1,      "lw_m_stall_req");
    expect_at(t+2, S_WE,    3'b010, "lw_m_bubble_in_e");
    expect_at(t+2, S_TNEW,  6'b000100, "lw_m_tnew");
    tick();
    stall = 1'b0;
    expect_at(t+3, S_STALL,   0,     "lw_w_no_stall");
    expect_at(t+3, S_RFWE,    1,     "lw_rf_we");
    expect_at(t+3, S_RFWADDR, 9,     "lw_rf_waddr");
    expect_at(t+3, S_RFWDSEL, 2'b01, "lw_rf_wdsel");
    tick();
    bubble(); q_rs = 5'd0;
    expect_at(t+4, S_WADDR, 15'd10, "addu_after_stall_waddr");
    expect_at(t+4, S_TNEW,  6'd1,   "addu_after_stall_tnew");
    tick(); tick(); tick();

    // 3. jal writes $31 from PC4 with Tnew 0; never stalls a reader of $31.
    t = cyc;
    drive(6'h03, 6'h00, 5'd0, 5'd0);
    q_rs = 5'd31; q_tuse_rs = 2'd0;
    expect_at(t+1, S_WADDR,   15'd31,    "jal_st_waddr");
    expect_at(t+1, S_WDSEL,   6'b000010, "jal_st_wdsel");
    expect_at(t+1, S_TNEW,    6'd0,      "jal_e_tnew");
    expect_at(t+1, S_STALL,   0,         "jal_e_stall_req");
    expect_at(t+2, S_STALL,   0,         "jal_m_stall_req");
    expect_at(t+2, S_TNEW,    6'd0,      "jal_m_tnew");
    expect_at(t+3, S_RFWADDR, 31,        "jal_rf_waddr");
    expect_at(t+3, S_RFWDSEL, 2'b10,     "jal_rf_wdsel");
    expect_at(t+3, S_RFWE,    1,         "jal_rf_we");
    expect_at(t+3, S_STALL,   0,         "jal_w_stall_req");
    expect_at(t+3, S_TNEW,    6'd0,      "jal_w_tnew");
    tick(); bubble();
    tick(); tick(); tick();
    q_rs = 5'd0;

    // 4. ori to $0 never writes; sw decodes to a bubble.
    t = cyc;
    drive(6'h0d, 6'h00, 5'd0, 5'd0);
    expect_at(t+1, S_WE,    0, "ori0_e_we");
    expect_at(t+1, S_STALL, 0, "ori0_stall_req");
    tick();
    drive(6'h2b, 6'h00, 5'd5, 5'd0);
    tick();
    bubble();
    expect_at(t+2, S_WE,    0, "sw_ori0_we");
    expect_at(t+2, S_WADDR, 0, "sw_ori0_waddr");
    expect_at(t+3, S_RFWE,  0, "ori0_rf_we");
    tick(); tick();

    // 5. Three records in flight, hold 2 cycles (stall masked), then flush+hold.
    t = cyc;
    drive(6'h00, 6'h23, 5'd1, 5'd4);
    tick();
    drive(6'h0f, 6'h00, 5'd6, 5'd0);
    tick();
    drive(6'h23, 6'h00, 5'd7, 5'd0);
    tick();
    drive(6'h00, 6'h21, 5'd0, 5'd12);
    hold = 1'b1; stall = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      expect_at(t+k, S_WE,    3'b111,                 $sformatf("hold_we_%0d", k));
      expect_at(t+k, S_WADDR, {5'd4, 5'd6, 5'd7},     $sformatf("hold_waddr_%0d", k));
      expect_at(t+k, S_WDSEL, 6'b000001,              $sformatf("hold_wdsel_%0d", k));
      expect_at(t+k, S_TNEW,  6'b000010,              $sformatf("hold_tnew_%0d", k));
    end
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; hold = 1'b0; stall = 1'b0;
    bubble();
    expect_at(t+6, S_WE,    0, "flush_we");
    expect_at(t+6, S_WADDR, 0, "flush_waddr");
    expect_at(t+6, S_TNEW,  0, "flush_tnew");
    expect_at(t+6, S_RFWE,  0, "flush_rf_we");
    expect_at(t+6, S5_WE,   0, "flush_we5");
    tick(); tick();

    // 6. Five-stage pipe: lw Tnew 2,1,0,0,0 and write-back after 5 cycles.
    t = cyc;
    drive(6'h23, 6'h00, 5'd9, 5'd0);
    expect_at(t+1, S5_WE,      5'b00001,      "s5_lw_we_e");
    expect_at(t+1, S5_TNEW,    10'd2,         "s5_lw_tnew_0");
    expect_at(t+2, S5_TNEW,    10'b0000000100, "s5_lw_tnew_1");
    expect_at(t+3, S5_TNEW,    10'd0,         "s5_lw_tnew_2");
    expect_at(t+3, S5_WE,      5'b00100,      "s5_lw_we_2");
    expect_at(t+4, S5_WE,      5'b01000,      "s5_lw_we_3");
    expect_at(t+4, S5_TNEW,    10'd0,         "s5_lw_tnew_3");
    expect_at(t+5, S5_RFWE,    1,             "s5_lw_rf_we");
    expect_at(t+5, S5_RFWADDR, 9,             "s5_lw_rf_waddr");
    expect_at(t+5, S5_RFWDSEL, 2'b01,         "s5_lw_rf_wdsel");
    expect_at(t+5, S5_TNEW,    10'd0,         "s5_lw_tnew_4");
    expect_at(t+6, S5_RFWE,    0,             "s5_lw_rf_we_gone");
    tick(); bubble();
    tick(); tick(); tick(); tick(); tick();

    // Reset pulse mid-flight discards the addu in both pipes.
    t = cyc;
    drive(6'h00, 6'h21, 5'd0, 5'd8);
    tick(); bubble();
    tick();
    rst_n = 1'b0;
    expect_at(t+2, S5_WE, 0, "rst_mid_we5");
    expect_at(t+2, S_WE,  0, "rst_mid_we");
    expect_at(t+2, S_RFWE, 0, "rst_mid_rf_we");
    tick();
    rst_n = 1'b1;
    expect_at(t+3, S5_WE,   0, "rst_mid_we5_held");
    expect_at(t+5, S5_RFWE, 0, "rst_mid_rf_we5");
    expect_at(t+5, S5_WE,   0, "rst_mid_we5_late");
    tick(); tick(); tick(); tick();

    // Anything still queued was never compared.
    foreach (sb[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s cyc=%0d actual=unchecked required=%0h",
               sb[i].name, sb[i].cyc, sb[i].val);
    end
    sb.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
